// File: rtl/compare_pipe_stats.sv
// compare_pipe_stats
//   Registered, streaming N-bit comparator with running statistics.
//   Operand pairs arrive over a valid/ready handshake. Each accepted pair is
//   compared under the selected mode, and the result sits in a one-deep output
//   register until downstream consumes it. Counters track the accepted pairs,
//   the pairs with a != b, and the index of the first mismatching pair.
//
// Ports
//   clk                 clock, rising edge
//   resetN              asynchronous active-low reset
//   inValid / inReady   input handshake (inReady = !outValid || outReady)
//   a, b                operands, N bits
//   mode                00 NE, 01 EQ, 10 LTU, 11 LTS (sampled at accept)
//   outValid / outReady output handshake
//   result              compare result of the held pair
//   resultNe            raw a != b of the held pair
//   clearStats          synchronous clear of all statistics
//   txnCount            accepted pairs, saturating
//   mismatchCount       accepted mismatching pairs, saturating
//   firstMismatchValid  a mismatch has been captured since reset/clear
//   firstMismatchIdx    txnCount value at the first mismatch
module compare_pipe_stats #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          inValid,
    output logic          inReady,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic [1:0]    mode,
    output logic          outValid,
    input  logic          outReady,
    output logic          result,
    output logic          resultNe,
    input  logic          clearStats,
    output logic [CW-1:0] txnCount,
    output logic [CW-1:0] mismatchCount,
    output logic          firstMismatchValid,
    output logic [CW-1:0] firstMismatchIdx
);

    localparam logic [N-1:0]  MSB_MASK = (N)'(1) << (N-1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic          accept;
    logic          ne;
    logic          ltu;
    logic          lts;
    logic          cmp;
    logic [N:0]    sub_u;
    logic [N:0]    sub_s;
    logic [N-1:0]  a_s;
    logic [N-1:0]  b_s;

    logic [CW-1:0] txn_base;
    logic [CW-1:0] mis_base;
    logic          fmv_base;
    logic [CW-1:0] fidx_base;
    logic [CW-1:0] txn_next;
    logic [CW-1:0] mis_next;
    logic          fmv_next;
    logic [CW-1:0] fidx_next;

    assign inReady = !outValid || outReady;
    assign accept  = inValid && inReady;

    // Unsigned less-than is the borrow out of an (N+1)-bit subtraction.
    // Signed less-than reuses it after flipping both MSBs, which maps the
    // two's-complement range onto the unsigned range in order.
    assign a_s   = a ^ MSB_MASK;
    assign b_s   = b ^ MSB_MASK;
    assign sub_u = {1'b0, a}   - {1'b0, b};
    assign sub_s = {1'b0, a_s} - {1'b0, b_s};
    assign ne    = |(a ^ b);
    assign ltu   = sub_u[N];
    assign lts   = sub_s[N];

    always_comb begin
        cmp = ne;
        case (mode)
            2'b00:   cmp = ne;
            2'b01:   cmp = ~ne;
            2'b10:   cmp = ltu;
            default: cmp = lts;
        endcase
    end

    // Output register: a new accept always loads, which also covers the
    // simultaneous consume-and-refill case without a bubble.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            outValid <= 1'b0;
            result   <= 1'b0;
            resultNe <= 1'b0;
        end else if (accept) begin
            outValid <= 1'b1;
            result   <= cmp;
            resultNe <= ne;
        end else if (outReady) begin
            outValid <= 1'b0;
        end
    end

    // Clear is applied first, so a pair accepted on the clear edge is
    // counted against the freshly cleared statistics.
    always_comb begin
        txn_base  = clearStats ? '0   : txnCount;
        mis_base  = clearStats ? '0   : mismatchCount;
        fmv_base  = clearStats ? 1'b0 : firstMismatchValid;
        fidx_base = clearStats ? '0   : firstMismatchIdx;

        txn_next  = txn_base;
        mis_next  = mis_base;
        fmv_next  = fmv_base;
        fidx_next = fidx_base;

        if (accept) begin
            if (txn_base != CNT_MAX) begin
                txn_next = txn_base + 1'b1;
            end
            if (ne) begin
                if (mis_base != CNT_MAX) begin
                    mis_next = mis_base + 1'b1;
                end
                if (!fmv_base) begin
                    fmv_next  = 1'b1;
                    fidx_next = txn_base;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            txnCount           <= '0;
            mismatchCount      <= '0;
            firstMismatchValid <= 1'b0;
            firstMismatchIdx   <= '0;
        end else begin
            txnCount           <= txn_next;
            mismatchCount      <= mis_next;
            firstMismatchValid <= fmv_next;
            firstMismatchIdx   <= fidx_next;
        end
    end

endmodule

// File: tb/tb_compare_pipe_stats.sv
// Bench for compare_pipe_stats. Three instances share one input stream:
//   u0: N=4, CW=8   u1: N=4, CW=2 (saturation)   u2: N=1, CW=2
// A behavioural model built from the compare/statistics rules predicts every
// output each cycle; directed steps add explicit constant checks.
module tb_compare_pipe_stats;

    logic       clk = 1'b0;
    logic       resetN;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] mode;
    logic       out_ready;
    logic       clear_stats;

    logic       in_ready [3];
    logic       out_valid [3];
    logic       res [3];
    logic       res_ne [3];
    logic       fmv [3];
    logic [7:0] txn0, mis0, fidx0;
    logic [1:0] txn1, mis1, fidx1;
    logic [1:0] txn2, mis2, fidx2;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int m_ov;
    int m_res [3];
    int m_ne  [3];
    int m_txn [3];
    int m_mis [3];
    int m_fmv [3];
    int m_fidx[3];
    int width [3] = '{4, 4, 1};
    int cmax  [3] = '{255, 3, 3};

    always #5 clk = ~clk;

    compare_pipe_stats #(.N(4), .CW(8)) u0 (
        .clk(clk), .resetN(resetN), .inValid(in_valid), .inReady(in_ready[0]),
        .a(a), .b(b), .mode(mode), .outValid(out_valid[0]), .outReady(out_ready),
        .result(res[0]), .resultNe(res_ne[0]), .clearStats(clear_stats),
        .txnCount(txn0), .mismatchCount(mis0), .firstMismatchValid(fmv[0]),
        .firstMismatchIdx(fidx0));

    compare_pipe_stats #(.N(4), .CW(2)) u1 (
        .clk(clk), .resetN(resetN), .inValid(in_valid), .inReady(in_ready[1]),
        .a(a), .b(b), .mode(mode), .outValid(out_valid[1]), .outReady(out_ready),
        .result(res[1]), .resultNe(res_ne[1]), .clearStats(clear_stats),
        .txnCount(txn1), .mismatchCount(mis1), .firstMismatchValid(fmv[1]),
        .firstMismatchIdx(fidx1));

    compare_pipe_stats #(.N(1), .CW(2)) u2 (
        .clk(clk), .resetN(resetN), .inValid(in_valid), .inReady(in_ready[2]),
        .a(a[0:0]), .b(b[0:0]), .mode(mode), .outValid(out_valid[2]), .outReady(out_ready),
        .result(res[2]), .resultNe(res_ne[2]), .clearStats(clear_stats),
        .txnCount(txn2), .mismatchCount(mis2), .firstMismatchValid(fmv[2]),
        .firstMismatchIdx(fidx2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_cmp(input int x, input int y, input int md, input int n);
        int xm, ym, xs, ys;
        xm = x % (1 << n);
        ym = y % (1 << n);
        xs = (xm >= (1 << (n - 1))) ? xm - (1 << n) : xm;
        ys = (ym >= (1 << (n - 1))) ? ym - (1 << n) : ym;
        case (md)
            0:       return int'(xm != ym);
            1:       return int'(xm == ym);
            2:       return int'(xm < ym);
            default: return int'(xs < ys);
        endcase
    endfunction

    task automatic model_reset();
        m_ov = 0;
        for (int k = 0; k < 3; k++) begin
            m_res[k] = 0; m_ne[k] = 0; m_txn[k] = 0;
            m_mis[k] = 0; m_fmv[k] = 0; m_fidx[k] = 0;
        end
    endtask

    // Applies one clock edge worth of rules using the inputs the DUT saw.
    task automatic model_edge();
        bit acc;
        int t, mm, ne;
        acc = in_valid && (m_ov == 0 || out_ready);
        for (int k = 0; k < 3; k++) begin
            ne = ((int'(a) % (1 << width[k])) != (int'(b) % (1 << width[k]))) ? 1 : 0;
            if (acc) begin
                m_res[k] = ref_cmp(int'(a), int'(b), int'(mode), width[k]);
                m_ne[k]  = ne;
            end
            if (clear_stats) begin
                m_txn[k] = 0; m_mis[k] = 0; m_fmv[k] = 0; m_fidx[k] = 0;
            end
            if (acc) begin
                t = m_txn[k];
                if (ne == 1 && m_fmv[k] == 0) begin
                    m_fmv[k]  = 1;
                    m_fidx[k] = t;
                end
                m_txn[k] = (t + 1 > cmax[k]) ? cmax[k] : t + 1;
                mm = m_mis[k] + ne;
                m_mis[k] = (mm > cmax[k]) ? cmax[k] : mm;
            end
        end
        if (acc) m_ov = 1;
        else if (out_ready) m_ov = 0;
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("outValid[%0d]", k), 32'(out_valid[k]), m_ov);
            chk($sformatf("result[%0d]", k), 32'(res[k]), m_res[k]);
            chk($sformatf("resultNe[%0d]", k), 32'(res_ne[k]), m_ne[k]);
            chk($sformatf("fmValid[%0d]", k), 32'(fmv[k]), m_fmv[k]);
        end
        chk("txnCount[0]", 32'(txn0), m_txn[0]);
        chk("mismatchCount[0]", 32'(mis0), m_mis[0]);
        chk("fmIdx[0]", 32'(fidx0), m_fidx[0]);
        chk("txnCount[1]", 32'(txn1), m_txn[1]);
        chk("mismatchCount[1]", 32'(mis1), m_mis[1]);
        chk("fmIdx[1]", 32'(fidx1), m_fidx[1]);
        chk("txnCount[2]", 32'(txn2), m_txn[2]);
        chk("mismatchCount[2]", 32'(mis2), m_mis[2]);
        chk("fmIdx[2]", 32'(fidx2), m_fidx[2]);
    endtask

    // Inputs must already be driven; checks inReady, takes one edge, checks outputs.
    task automatic cycle();
        #1;
        for (int k = 0; k < 3; k++)
            chk($sformatf("inReady[%0d]", k), 32'(in_ready[k]), (m_ov == 0 || out_ready) ? 1 : 0);
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input int x, input int y, input int md);
        in_valid = v;
        a        = 4'(x);
        b        = 4'(y);
        mode     = 2'(md);
    endtask

    int exp_stream [4] = '{0, 0, 0, 1};
    int sb_a [6] = '{8, 7, 8, 8, 7, 8};
    int sb_b [6] = '{7, 8, 8, 7, 8, 8};
    int sb_m [6] = '{3, 3, 3, 2, 2, 2};
    int sb_r [6] = '{1, 0, 0, 0, 1, 0};
    int t0;

    initial begin
        resetN = 1'b0; clear_stats = 1'b0; out_ready = 1'b1;
        drive(0, 0, 0, 0);
        model_reset();
        #12;
        check_all();
        resetN = 1'b1;
        @(posedge clk); #1;

        // reset while a result is stalled
        out_ready = 1'b0;
        drive(1, 3, 5, 0);
        cycle();
        chk("stall_outValid", 32'(out_valid[0]), 1);
        in_valid = 1'b0;
        #1 resetN = 1'b0;
        #1;
        model_reset();
        chk("rst_outValid", 32'(out_valid[0]), 0);
        chk("rst_inReady", 32'(in_ready[0]), 1);
        chk("rst_txn", 32'(txn0), 0);
        check_all();
        #1 resetN = 1'b1;
        out_ready = 1'b1;

        // back-to-back stream
        drive(1, 3, 3, 0); cycle(); chk("stream0", 32'(res[0]), exp_stream[0]);
        drive(1, 3, 5, 1); cycle(); chk("stream1", 32'(res[0]), exp_stream[1]);
        drive(1, 5, 3, 2); cycle(); chk("stream2", 32'(res[0]), exp_stream[2]);
        drive(1, 15, 1, 3); cycle(); chk("stream3", 32'(res[0]), exp_stream[3]);
        chk("stream_txn", 32'(txn0), 4);
        chk("stream_mis", 32'(mis0), 3);
        chk("stream_fidx", 32'(fidx0), 1);

        // backpressure
        drive(0, 0, 0, 0); cycle();
        t0 = int'(txn0);
        out_ready = 1'b0;
        drive(1, 9, 2, 2);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_result", 32'(res[0]), 0);
            drive(1, 2, 9, 2);
        end
        chk("bp_inReady", 32'(in_ready[0]), 0);
        chk("bp_txn", 32'(txn0), t0 + 1);
        out_ready = 1'b1;
        cycle();
        chk("bp_release_txn", 32'(txn0), t0 + 2);
        chk("bp_release_result", 32'(res[0]), 1);
        chk("bp_release_valid", 32'(out_valid[0]), 1);

        // saturation on the CW=2 instance
        drive(0, 0, 0, 0); clear_stats = 1'b1; cycle(); clear_stats = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1, i, i ^ 1, 0); cycle();
        end
        chk("sat_txn", 32'(txn1), 3);
        chk("sat_mis", 32'(mis1), 3);
        chk("sat_fidx", 32'(fidx1), 0);
        chk("sat_txn_wide", 32'(txn0), 6);

        // clear colliding with a mismatching accept
        drive(0, 0, 0, 0); clear_stats = 1'b1; cycle(); clear_stats = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1, i, i, 1); cycle();
        end
        chk("pre_clr_txn", 32'(txn0), 5);
        clear_stats = 1'b1; drive(1, 6, 2, 0); cycle(); clear_stats = 1'b0;
        chk("clr_txn", 32'(txn0), 1);
        chk("clr_mis", 32'(mis0), 1);
        chk("clr_fmv", 32'(fmv[0]), 1);
        chk("clr_fidx", 32'(fidx0), 0);

        // signed/unsigned boundaries
        for (int i = 0; i < 6; i++) begin
            drive(1, sb_a[i], sb_b[i], sb_m[i]); cycle();
            chk($sformatf("bound%0d", i), 32'(res[0]), sb_r[i]);
        end
        drive(1, 1, 0, 3); cycle();
        chk("n1_lts", 32'(res[2]), 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 15),
                  ($urandom_range(0, 2) == 0) ? int'(a) : $urandom_range(0, 15),
                  $urandom_range(0, 3));
            out_ready   = ($urandom_range(0, 3) != 0);
            clear_stats = ($urandom_range(0, 31) == 0);
            cycle();
        end
        clear_stats = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/compare_pipe_stats.md
Name: compare_pipe_stats

Overview:
- Parametrised, registered successor to the team's combinational N-bit inequality comparator.
- Accepts a stream of operand pairs over a valid/ready handshake. Each accepted pair is compared under a selectable mode, and the result is returned one cycle later through a registered output stage.
- Keeps running statistics: accepted pairs, pairs with a != b, and the index of the first mismatch.
- Sits between the multiplier datapath and the self-check/status logic, for checking result streams against expected values.

Parameters:
- N, 4: operand width in bits (N >= 1).
- CW, 8: width of the transaction and mismatch counters (CW >= 2).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- resetN  input  1  asynchronous, active-low reset.
- inValid  input  1  operand pair valid.
- inReady  output  1  block can accept a pair this cycle.
- a  input  N  operand A.
- b  input  N  operand B.
- mode  input  2  compare mode: 00 NE (a!=b), 01 EQ (a==b), 10 LTU (a<b unsigned), 11 LTS (a<b two's-complement signed).
- outValid  output  1  result register holds an unconsumed result.
- outReady  input  1  downstream consumes the result this cycle.
- result  output  1  compare result for the pair held in the output register.
- resultNe  output  1  raw a!=b for the same pair, independent of mode.
- clearStats  input  1  synchronous clear of all statistics.
- txnCount  output  CW  number of accepted pairs since reset/clear; saturates at 2^CW-1.
- mismatchCount  output  CW  accepted pairs with a!=b since reset/clear; saturates at 2^CW-1.
- firstMismatchValid  output  1  a mismatch has been captured since reset/clear.
- firstMismatchIdx  output  CW  txnCount value (0-based index) of the first mismatching pair.

Behaviour:
- Reset (resetN low, asynchronous, any cycle including mid-transfer): all outputs and state go to 0 and the pending result is discarded.
  - Reset values: outValid=0, result=0, resultNe=0, txnCount=0, mismatchCount=0, firstMismatchValid=0, firstMismatchIdx=0.
  - inReady=1 as soon as outValid=0.
- Accept: a pair is accepted when inValid && inReady.
  - inReady = !outValid || outReady (combinational; full throughput, one pair per cycle).
- Latency: the pair accepted at edge k appears with result/resultNe and outValid=1 after edge k.
- Output hold: while outValid && !outReady, result, resultNe and outValid hold stable and inReady=0.
- Output transitions on each edge:
  - Handshake out with no new accept: outValid -> 0.
  - Simultaneous out and in handshakes: the register loads the new pair and outValid stays 1, with no bubble.
- Mode semantics:
  - NE: result = |(a^b).
  - EQ: result = ~|(a^b).
  - LTU: unsigned a<b via an (N+1)-bit subtraction borrow.
  - LTS: signed a<b; compares with the MSB inverted.
  - Mode is sampled at accept only.
- Statistics (updated only on accept, independent of the output handshake):
  - txnCount increments by 1 and saturates at 2^CW-1.
  - mismatchCount increments by 1 if a!=b and saturates at 2^CW-1.
  - On the first accepted mismatch since reset/clear: firstMismatchIdx <= current txnCount (pre-increment value, saturated) and firstMismatchValid <= 1. Later mismatches do not change it.
- clearStats: on the edge, statistics go to 0 and firstMismatchValid goes to 0.
  - If an accept coincides with clear, that pair is counted as index 0 after the clear (txnCount=1; on mismatch, mismatchCount=1, firstMismatchValid=1, firstMismatchIdx=0).
  - clearStats does not affect the output register or the handshake.
- N=1 is legal. LTS with N=1: 1 (-1) < 0 (0) is true.

Test Plan:
- Reset mid-stall: accept a=3,b=5 NE, hold outReady=0, pulse resetN low asynchronously -> outValid=0 immediately, all counters 0, inReady=1.
- Streaming, N=4, outReady=1: 4 back-to-back pairs (3,3 NE), (3,5 EQ), (5,3 LTU), (F,1 LTS) -> results 0,0,0,1 on consecutive cycles one cycle after each accept; resultNe 0,1,1,1; txnCount=4, mismatchCount=3, firstMismatchIdx=1.
- Backpressure: outReady=0 for 3 cycles with inValid=1 -> exactly one pair accepted, result held stable, inReady=0, txnCount increments once; release outReady -> next pair accepted the same cycle, no bubble.
- Saturation, CW=2: accept 6 mismatching pairs -> txnCount and mismatchCount stop at 3, firstMismatchIdx=0.
- Clear collision: after 5 matching pairs, assert clearStats together with an accepted mismatching pair (6,2) -> txnCount=1, mismatchCount=1, firstMismatchValid=1, firstMismatchIdx=0.
- Signed boundaries, N=4, LTS: (8,7) -> 1; (7,8) -> 0; (8,8) -> 0. Same pairs in LTU -> 0,1,0.
